avm_uart_responder: RTL and testbench

Avalon-MM slave that implements the three-register UART interface polled by the RSA wrapper: RX data, TX data and status. It deserializes 8N1 bytes from `uart_rxd` into an RX holding register and serializes bytes written to TX data onto `uart_txd`. It sits between the board serial pins and the Avalon-MM master, and is also the bus model used in wrapper simulation.

---
 rtl/uart_avm_pkg.sv | 28 ++
 rtl/uart_rx_deser.sv | 94 +++++++++
 rtl/avm_uart_responder.sv | 208 ++++++++++++++++++++
 tb/tb_avm_uart_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_avm_pkg.sv
// Shared constants for the Avalon-MM UART register map and FSM state types.
// The RSA wrapper imports the same offsets and status bit positions.
package uart_avm_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;
  localparam int OVR_BIT   = 5;
  localparam int FRM_BIT   = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receiver: two-flop synchronizer, start-edge detect and mid-bit sampling.
// Emits the received byte with a one-cycle valid pulse or framing-error pulse.
module uart_rx_deser
  import uart_avm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frm_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;

  assign rx_s   = sync_q[1];
  assign byte_o = shift_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    valid_o   = 1'b0;
    frm_err_o = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        // A line that is high again at mid-start was only a glitch.
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          state_d   = RX_IDLE;
          valid_o   = rx_s;
          frm_err_o = !rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/avm_uart_responder.sv
// Avalon-MM UART slave: RX data / TX data / STATUS registers with one wait state,
// 8N1 receiver sub-module and a double-buffered 8N1 transmitter.
module avm_uart_responder
  import uart_avm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  logic        req, ack_q, ack_d;
  logic        rd_done, wr_done;
  logic        rx_rd_done, stat_rd_done, tx_wr_done;
  logic [7:0]  status;
  logic [31:0] readdata_q, readdata_d;

  logic [7:0]  rx_byte, rx_byte_q, rx_byte_d;
  logic        rx_valid, rx_frm;
  logic        rx_ok_q, rx_ok_d;
  logic        ovr_q, ovr_d;
  logic        frm_q, frm_d;

  logic        tx_ok_q, tx_ok_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  logic        unused_wdata;
  assign unused_wdata = ^avm_writedata[31:8];

  uart_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i     (avm_clk),
    .rst_i     (avm_rst),
    .rxd_i     (uart_rxd),
    .byte_o    (rx_byte),
    .valid_o   (rx_valid),
    .frm_err_o (rx_frm)
  );

  // Every access stalls exactly one cycle; it completes while ack_q is high.
  assign req             = avm_read | avm_write;
  assign ack_d           = req & ~ack_q;
  assign avm_waitrequest = req & ~ack_q;
  assign rd_done         = ack_q & avm_read;
  assign wr_done         = ack_q & avm_write & ~avm_read;
  assign rx_rd_done      = rd_done && (avm_address == RX_BASE);
  assign stat_rd_done    = rd_done && (avm_address == STATUS_BASE);
  assign tx_wr_done      = wr_done && (avm_address == TX_BASE);

  assign avm_readdata = readdata_q;
  assign uart_txd     = txd_q;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      ack_q      <= 1'b0;
      readdata_q <= '0;
      rx_byte_q  <= '0;
      rx_ok_q    <= 1'b0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      tx_ok_q    <= 1'b1;
      tx_hold_q  <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      ack_q      <= ack_d;
      readdata_q <= readdata_d;
      rx_byte_q  <= rx_byte_d;
      rx_ok_q    <= rx_ok_d;
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      tx_ok_q    <= tx_ok_d;
      tx_hold_q  <= tx_hold_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Register file: read capture in the wait cycle, side effects on completion.
  always_comb begin
    status            = '0;
    status[RX_OK_BIT] = rx_ok_q;
    status[TX_OK_BIT] = tx_ok_q;
    status[OVR_BIT]   = ovr_q;
    status[FRM_BIT]   = frm_q;

    readdata_d = readdata_q;
    if (avm_read && !ack_q) begin
      case (avm_address)
        RX_BASE:     readdata_d = {24'b0, rx_byte_q};
        STATUS_BASE: readdata_d = {24'b0, status};
        default:     readdata_d = '0;
      endcase
    end

    rx_byte_d = rx_byte_q;
    rx_ok_d   = rx_ok_q;
    ovr_d     = ovr_q;
    frm_d     = frm_q;

    if (stat_rd_done) begin
      ovr_d = 1'b0;
      frm_d = 1'b0;
    end
    // A byte landing as the RX read completes replaces the one being read.
    if (rx_valid) begin
      if (rx_ok_q && !rx_rd_done) begin
        ovr_d = 1'b1;
      end else begin
        rx_byte_d = rx_byte;
        rx_ok_d   = 1'b1;
      end
    end else if (rx_rd_done) begin
      rx_ok_d = 1'b0;
    end
    if (rx_frm) frm_d = 1'b1;
  end

  // TX serializer; reloads from the holding register at the end of a stop bit
  // so queued frames leave without an idle gap.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_W'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_ok_d    = tx_ok_q;
    tx_hold_d  = tx_hold_q;

    if (tx_wr_done && tx_ok_q) begin
      tx_hold_d = avm_writedata[7:0];
      tx_ok_d   = 1'b0;
    end

    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (!tx_ok_q) begin
          tx_shift_d = tx_hold_q;
          tx_ok_d    = 1'b1;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (!tx_ok_q) begin
            tx_shift_d = tx_hold_q;
            tx_ok_d    = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_avm_uart_responder.sv
// Self-checking bench for avm_uart_responder at CLKS_PER_BIT = 16: register-map
// table, serial RX frames, back-to-back TX frames and reset during a frame.
module tb_avm_uart_responder;
  import uart_avm_pkg::*;

  localparam int CPB = 16;

  logic        avm_clk = 1'b0;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        uart_rxd;
  logic        uart_txd;

  avm_uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd)
  );

  always #5 avm_clk = ~avm_clk;

  int unsigned cyc = 0;
  always @(posedge avm_clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_RW} op_e;
  typedef struct {
    op_e         op;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] bus_exp[$];
  logic        tx_exp[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_xfer(input logic rd, input logic wr, input logic [4:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata, output int waits);
    @(negedge avm_clk);
    avm_address   = a;
    avm_read      = rd;
    avm_write     = wr;
    avm_writedata = wd;
    waits         = 0;
    #1;
    while (avm_waitrequest && waits < 8) begin
      @(negedge avm_clk);
      #1;
      waits++;
    end
    rdata = avm_readdata;
    @(negedge avm_clk);
    avm_read  = 1'b0;
    avm_write = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          w;
    bus_exp.push_back(exp);
    bus_xfer(1'b1, 1'b0, a, 32'h0, rd, w);
    check(name, rd, bus_exp.pop_front());
    check({name, "_wait"}, w, 1);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int          w;
    bus_xfer(1'b0, 1'b1, a, d, rd, w);
  endtask

  task automatic poll_tx_ok(input string name);
    logic [31:0] rd;
    int          w;
    logic        ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      bus_xfer(1'b1, 1'b0, STATUS_BASE, 32'h0, rd, w);
      ok = rd[TX_OK_BIT];
    end
    check(name, ok, 1);
  endtask

  task automatic push_frame(input logic [7:0] b);
    tx_exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_exp.push_back(b[i]);
    tx_exp.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge avm_clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge avm_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge avm_clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge avm_clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge avm_clk);
  endtask

  task automatic tx_monitor(input int nframes);
    int unsigned start_cyc[2];
    int          waited;
    logic        went_low = 1'b0;
    for (int f = 0; f < nframes; f++) begin
      waited = 0;
      while (uart_txd !== 1'b0 && waited < 2000) begin
        @(negedge avm_clk);
        waited++;
      end
      if (waited >= 2000) begin
        check($sformatf("tx_f%0d_timeout", f), 1, 0);
        return;
      end
      start_cyc[f] = cyc;
      repeat (CPB / 2) @(negedge avm_clk);
      for (int b = 0; b < 10; b++) begin
        if (tx_exp.size() == 0) begin
          check($sformatf("tx_f%0d_b%0d_unexpected", f, b), 1, 0);
        end else begin
          check($sformatf("tx_f%0d_b%0d", f, b), uart_txd, tx_exp.pop_front());
        end
        if (b < 9) repeat (CPB) @(negedge avm_clk);
      end
    end
    if (nframes == 2) check("tx_back_to_back", start_cyc[1] - start_cyc[0], 10 * CPB);
    repeat (200) begin
      @(negedge avm_clk);
      if (uart_txd !== 1'b1) went_low = 1'b1;
    end
    check("tx_dropped_write_idle", went_low, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    logic        low_seen;

    vecs[0] = '{OP_RD, STATUS_BASE, 32'h0,  32'h40};
    vecs[1] = '{OP_RD, RX_BASE,     32'h0,  32'h00};
    vecs[2] = '{OP_RD, 5'h0C,       32'h0,  32'h00};
    vecs[3] = '{OP_RD, TX_BASE,     32'h0,  32'h00};
    vecs[4] = '{OP_WR, 5'h10,       32'hFF, 32'h00};
    vecs[5] = '{OP_RW, TX_BASE,     32'h99, 32'h00};
    vecs[6] = '{OP_RD, STATUS_BASE, 32'h0,  32'h40};
    vecs[7] = '{OP_RD, 5'h1C,       32'h0,  32'h00};

    avm_rst = 1'b1; avm_read = 1'b0; avm_write = 1'b0;
    avm_address = '0; avm_writedata = '0; uart_rxd = 1'b1;
    repeat (3) @(negedge avm_clk);
    avm_rst = 1'b0;
    @(negedge avm_clk);
    check("rst_readdata", avm_readdata, 32'h0);
    check("rst_waitrequest", avm_waitrequest, 0);
    check("rst_txd", uart_txd, 1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].op != OP_WR) bus_exp.push_back(vecs[i].exp);
      bus_xfer(vecs[i].op != OP_WR, vecs[i].op != OP_RD, vecs[i].addr, vecs[i].wdata, rd, w);
      check($sformatf("vec%0d_wait", i), w, 1);
      if (vecs[i].op != OP_WR) check($sformatf("vec%0d_rdata", i), rd, bus_exp.pop_front());
    end
    low_seen = 1'b0;
    repeat (40) begin
      @(negedge avm_clk);
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    check("rw_write_ignored", low_seen, 0);

    send_frame(8'hA5, 1'b1);
    read_check("rx_a5_status", STATUS_BASE, 32'hC0);
    read_check("rx_a5_data", RX_BASE, 32'hA5);
    read_check("rx_a5_status_after", STATUS_BASE, 32'h40);

    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    read_check("ovr_status", STATUS_BASE, 32'hE0);
    read_check("ovr_data", RX_BASE, 32'h12);
    read_check("ovr_status_after", STATUS_BASE, 32'h40);

    send_frame(8'h55, 1'b0);
    read_check("frm_status", STATUS_BASE, 32'h50);
    read_check("frm_status_cleared", STATUS_BASE, 32'h40);

    @(negedge avm_clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge avm_clk);
    uart_rxd = 1'b1;
    repeat (10 * CPB) @(negedge avm_clk);
    read_check("glitch_status", STATUS_BASE, 32'h40);
    read_check("glitch_rx_stale", RX_BASE, 32'h12);

    send_frame(8'h81, 1'b1);
    read_check("rx_81_status", STATUS_BASE, 32'hC0);
    read_check("rx_81_data", RX_BASE, 32'h81);

    fork
      tx_monitor(2);
      begin
        poll_tx_ok("tx_ok_poll_1");
        push_frame(8'h3C);
        write_reg(TX_BASE, 32'h3C);
        check("tx_start_t1", uart_txd, 1);
        @(negedge avm_clk);
        check("tx_start_t2", uart_txd, 0);
        poll_tx_ok("tx_ok_poll_2");
        push_frame(8'h5A);
        write_reg(TX_BASE, 32'h5A);
        read_check("tx_hold_full_status", STATUS_BASE, 32'h00);
        write_reg(TX_BASE, 32'hFF);
      end
    join
    check("tx_queue_drained", tx_exp.size(), 0);

    write_reg(TX_BASE, 32'hC3);
    repeat (6) @(negedge avm_clk);
    check("tx_pre_reset_start_bit", uart_txd, 0);
    avm_rst = 1'b1;
    #1;
    check("tx_reset_immediate", uart_txd, 1);
    repeat (3) @(negedge avm_clk);
    avm_rst = 1'b0;
    read_check("post_reset_status", STATUS_BASE, 32'h40);
    low_seen = 1'b0;
    repeat (12 * CPB) begin
      @(negedge avm_clk);
      if (uart_txd !== 1'b1) low_seen = 1'b1;
    end
    check("post_reset_tx_idle", low_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
